// File: rtl/flash_spi_pkg.sv
// Shared SPI flash constants and the state encoding of the WIP polling sequencer.
package flash_spi_pkg;

  localparam logic [7:0] INST_WREN = 8'h06;
  localparam logic [7:0] INST_BE   = 8'hC7;
  localparam logic [7:0] INST_RDSR = 8'h05;

  localparam int WIP_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SEND_INST,
    ST_READ_SR,
    ST_CS_HOLD,
    ST_GAP
  } poll_state_t;

endpackage

// File: rtl/spi_mode0_byte.sv
// SPI mode-0 byte engine: one byte out on mosi and one in from miso, CLK_DIV sys_clk per bit.
module spi_mode0_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       bit_done,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  localparam int             PH_W    = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV / 2);

  logic            active;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nx;
  logic [2:0]      bit_idx;
  logic [7:0]      tx_sh;

  assign phase_nx  = phase + PH_W'(1);
  assign bit_done  = active && (phase == PH_LAST);
  assign byte_done = bit_done && (bit_idx == 3'd7);

  // A load on the last cycle of a byte chains straight into the next byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      active  <= 1'b0;
      phase   <= '0;
      bit_idx <= '0;
      tx_sh   <= '0;
      rx_byte <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      phase   <= '0;
      bit_idx <= '0;
      tx_sh   <= {tx_byte[6:0], 1'b0};
      mosi    <= tx_byte[7];
      sck     <= 1'b0;
    end else if (active) begin
      if (phase == PH_LAST) begin
        phase <= '0;
        sck   <= 1'b0;
        if (bit_idx == 3'd7) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 3'd1;
          mosi    <= tx_sh[7];
          tx_sh   <= {tx_sh[6:0], 1'b0};
        end
      end else begin
        phase <= phase_nx;
        sck   <= (phase_nx >= PH_RISE);
        // miso is captured on the same sys_clk edge that raises sck.
        if (phase_nx == PH_RISE) begin
          rx_byte <= {rx_byte[6:0], miso};
        end
      end
    end
  end

endmodule

// File: rtl/flash_wip_poll.sv
// Polls the flash status register with RDSR frames until WIP clears or the poll budget runs out.
module flash_wip_poll
  import flash_spi_pkg::*;
#(
  parameter int          CLK_DIV       = 4,
  parameter int          GAP_CLK       = 32,
  parameter logic [23:0] TIMEOUT_POLLS = 24'd10_000_000,
  parameter logic [7:0]  RDSR_INST     = INST_RDSR
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       miso,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] status
);

  localparam int TMR_MAX = (GAP_CLK > CLK_DIV) ? GAP_CLK : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] LAST_DIV = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] LAST_GAP = TMR_W'(GAP_CLK - 1);

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFF_FFFF) ? v : v + 24'd1;
  endfunction

  poll_state_t      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [23:0]      poll_q, poll_d, poll_inc;
  logic             cs_n_d, busy_d, done_d, timeout_d;
  logic [7:0]       status_d;

  logic       load;
  logic [7:0] tx_byte;
  logic       bit_done, byte_done, byte_end;
  logic [7:0] rx_byte;

  spi_mode0_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load      (load),
    .tx_byte   (tx_byte),
    .miso      (miso),
    .sck       (sck),
    .mosi      (mosi),
    .bit_done  (bit_done),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  assign byte_end = bit_done && byte_done;
  assign poll_inc = sat_inc(poll_q);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      poll_q  <= '0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      status  <= 8'h00;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      poll_q  <= poll_d;
      cs_n    <= cs_n_d;
      busy    <= busy_d;
      done    <= done_d;
      timeout <= timeout_d;
      status  <= status_d;
    end
  end

  // Next-state logic also produces the registered output values for the next cycle.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    poll_d    = poll_q;
    cs_n_d    = cs_n;
    busy_d    = busy;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    status_d  = status;
    load      = 1'b0;
    tx_byte   = RDSR_INST;
    unique case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_CS_SETUP;
          tmr_d   = '0;
          poll_d  = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        if (tmr_q == LAST_DIV) begin
          load    = 1'b1;
          tx_byte = RDSR_INST;
          tmr_d   = '0;
          state_d = ST_SEND_INST;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SEND_INST: begin
        if (byte_end) begin
          load    = 1'b1;
          tx_byte = 8'h00;
          state_d = ST_READ_SR;
        end
      end
      ST_READ_SR: begin
        if (byte_end) begin
          status_d = rx_byte;
          tmr_d    = '0;
          state_d  = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (tmr_q == LAST_DIV) begin
          tmr_d  = '0;
          cs_n_d = 1'b1;
          if (!status[WIP_BIT]) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            poll_d = poll_inc;
            if (poll_inc >= TIMEOUT_POLLS) begin
              timeout_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == LAST_GAP) begin
          tmr_d   = '0;
          cs_n_d  = 1'b0;
          state_d = ST_CS_SETUP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/flash_wip_poll.md
Name: flash_wip_poll

Overview:
- Downstream stage of the SPI flash bulk-erase controller.
- After the erase command frame completes, it repeatedly issues Read Status Register (RDSR, 0x05) frames.
- It keeps polling until the Write-In-Progress bit (status bit 0) clears, or until a poll budget runs out.
- It reports completion with done or timeout pulses and owns the SPI bus (sck, cs_n, mosi, miso) while busy.

Parameters:
- CLK_DIV, 4: sys_clk cycles per sck period. Must be even and ≥4. sck is low for the first half and high for the second half.
- GAP_CLK, 32: sys_clk cycles cs_n is held high between consecutive poll frames.
- TIMEOUT_POLLS, 24'd10_000_000: maximum number of RDSR frames before giving up. Width is 24.
- RDSR_INST, 8'h05: status-read instruction.

Ports:
- sys_clk  input  1  system clock (50 MHz nominal).
- sys_rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse from the erase controller at the end of its erase frame.
- miso  input  1  flash serial data out.
- sck  output  1  SPI clock, mode 0, idle low.
- cs_n  output  1  flash chip select, active low.
- mosi  output  1  SPI data to flash, MSB first.
- busy  output  1  high from the cycle after an accepted start until the cycle done/timeout is asserted.
- done  output  1  one-cycle pulse: WIP read as 0.
- timeout  output  1  one-cycle pulse: poll budget exhausted with WIP still 1.
- status  output  8  last complete status byte read.

Behaviour:
- All outputs are registered.
- Reset values: sck=0, cs_n=1, mosi=0, busy=0, done=0, timeout=0, status=8'h00. Internal counters are 0 and the state is IDLE.
- State machine: IDLE → CS_SETUP → SEND_INST → READ_SR → CS_HOLD → (IDLE | GAP), and GAP → CS_SETUP.
- IDLE: cs_n=1, sck=0, mosi=0. start=1 is accepted, busy goes 1 and the poll counter clears; next state is CS_SETUP.
- CS_SETUP: cs_n=0 and sck=0 for CLK_DIV cycles.
- SEND_INST: 8 bits, CLK_DIV cycles each, driven from a phase counter 0..CLK_DIV-1.
  - mosi is updated at phase 0 with RDSR_INST[7-bit].
  - sck=1 for phases ≥ CLK_DIV/2.
- READ_SR: 8 bits with the same timing.
  - mosi=0.
  - miso is sampled on the sys_clk edge where sck rises (phase==CLK_DIV/2) and shifted in MSB first.
  - status is updated with the full byte at the end of bit 7.
- CS_HOLD: sck=0 and cs_n=0 for CLK_DIV cycles. At its last cycle:
  - status[0]==0 → done pulses in the next cycle, busy→0, state→IDLE.
  - else the poll counter increments. If the counter reaches TIMEOUT_POLLS → timeout pulses in the next cycle, busy→0, state→IDLE.
  - else → GAP.
- GAP: cs_n=1, sck=0 for GAP_CLK cycles, then → CS_SETUP.
- Each frame has exactly 16 sck rising edges and returns sck low before cs_n rises.
- Latency with defaults, start seen at edge 0:
  - CS_SETUP covers cycles 1–4, SEND_INST 5–36, READ_SR 37–68, CS_HOLD 69–72.
  - done/timeout is high in cycle 73.
  - Poll period is 104 cycles.
- start while busy=1 is ignored; counters are not restarted.
- done and timeout are mutually exclusive and never assert without a preceding accepted start.
- Reset asserted mid-frame forces every output to its reset value immediately, including cs_n=1, sck=0, and no done/timeout.
- The poll counter saturates; it never wraps.

Decomposition:
- Package flash_spi_pkg holds:
  - instruction constants: WREN 8'h06, BE 8'hC7, RDSR 8'h05;
  - WIP_BIT=0;
  - the state encoding for this FSM.
- One sub-module, spi_mode0_byte: shifts one byte out on mosi and one in from miso with CLK_DIV timing, and exposes bit_done/byte_done strobes.
- The top-level FSM sequences two byte transfers per frame.

Test Plan:
1. Flash model returns 0x00 on the first read; pulse start → mosi bits on sck rising edges are 0x05, status=8'h00, done high exactly in cycle 73, busy low in cycle 73, one cs_n frame only.
2. Model returns 0x03, 0x03, 0x03, then 0x02 → 4 frames, cs_n high ≥32 cycles between frames, done once at cycle 73+3*104=385, status=8'h02.
3. TIMEOUT_POLLS=4, model always returns 0x01 → 4 frames, timeout pulse in cycle 385, done never, status=8'h01.
4. Second start pulse in cycle 20 of a poll → ignored; timing identical to scenario 1.
5. sys_rst asserted at cycle 15 (inside SEND_INST) → cs_n=1, sck=0, mosi=0, busy=0 in the same cycle. After release, a new start yields scenario 1 timing.
6. Protocol monitor across all runs → sck only toggles while cs_n=0, mosi stable while sck high, 16 sck rising edges per frame.
